// File: rtl/dmem_hs_ctrl_pkg.sv
// Shared types for the data-memory handshake controller.
//   mem_op_e   : LSU operation encoding (loads 0..4, stores 5..7)
//   mem_size_e : access width derived from the op
//   state_e    : controller FSM states
//   is_load / is_store / op_size : op classification helpers
package dmem_hs_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_IDLE      = 2'd1,
        ST_LOAD_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    function automatic logic is_load(mem_op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic mem_size_e op_size(mem_op_e op);
        mem_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_hs_ctrl_if.sv
// Request/response handshake bundle between the LSU (master) and the
// data memory (slave).
//   req_valid/req_ready/req_op/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err          : response channel
interface dmem_hs_ctrl_if;
    import dmem_hs_ctrl_pkg::*;

    logic        req_valid;
    logic        req_ready;
    mem_op_e     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_hs_ctrl_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   op, lane      : operation and byte offset within the word (addr[1:0])
//   wdata         : right-aligned store data
//   rword         : raw RAM word for loads
//   be, wdata_al  : per-byte write enable and lane-replicated store data
//   rdata         : extracted and sign/zero-extended load result (0 for stores)
//   misalign      : half access on odd byte or word access off a word boundary
module dmem_hs_ctrl_lane_align
    import dmem_hs_ctrl_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata,
    output logic        misalign
);

    mem_size_e   sz;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        sz       = op_size(op);
        rbyte    = rword[{lane, 3'b000} +: 8];
        rhalf    = lane[1] ? rword[31:16] : rword[15:0];
        misalign = ((sz == SZ_H) && lane[0]) || ((sz == SZ_W) && (lane != 2'b00));

        // Store data is replicated across lanes so the byte enable alone
        // selects the destination bytes.
        be       = 4'b0000;
        wdata_al = wdata;
        if (is_store(op)) begin
            case (sz)
                SZ_B: begin
                    be       = 4'b0001 << lane;
                    wdata_al = {4{wdata[7:0]}};
                end
                SZ_H: begin
                    be       = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_al = {2{wdata[15:0]}};
                end
                default: begin
                    be       = 4'b1111;
                    wdata_al = wdata;
                end
            endcase
        end

        case (op)
            OP_LB:   rdata = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  rdata = {24'h0, rbyte};
            OP_LH:   rdata = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  rdata = {16'h0, rhalf};
            OP_LW:   rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_hs_ctrl.sv
// RV32 data memory with valid/ready request and response channels.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : request/response handshake, one request outstanding
//   busy_clr     : high while the post-reset zero-fill walks the array
// Loads respond RD_LAT+1 cycles after accept; stores and errors respond
// the cycle after accept. Errors (misaligned or beyond DEPTH*4) never touch
// the array and return rdata=0.
module dmem_hs_ctrl
    import dmem_hs_ctrl_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int CLR_EN = 1
)(
    input  logic            clk,
    input  logic            reset_n,
    dmem_hs_ctrl_if.slave   bus,
    output logic            busy_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam state_e RST_STATE = (CLR_EN != 0) ? ST_CLEAR : ST_IDLE;

    state_e          state, state_nx;
    logic [AW-1:0]   clr_ptr;
    logic [2:0]      lat_cnt;
    mem_op_e         op_q;
    logic [AW-1:0]   word_q;
    logic [1:0]      lane_q;
    logic            req_ready_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            range_err;
    logic            req_err;
    logic            lat_done;
    mem_op_e         al_op;
    logic [1:0]      al_lane;
    logic [31:0]     rword;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata;
    logic [31:0]     al_rdata;
    logic            al_misalign;

    logic [3:0]      we_be;
    logic [AW-1:0]   we_idx;
    logic [31:0]     we_data;

    assign accept    = bus.req_valid & req_ready_q;
    assign range_err = |bus.req_addr[31:AW+2];
    assign req_err   = al_misalign | range_err;
    assign lat_done  = (lat_cnt == 3'(RD_LAT - 1));
    assign rword     = mem[word_q];

    // One aligner serves both directions: it sees the live request while
    // idle (decode + store steering) and the registered op during load wait.
    assign al_op   = (state == ST_LOAD_WAIT) ? op_q   : bus.req_op;
    assign al_lane = (state == ST_LOAD_WAIT) ? lane_q : bus.req_addr[1:0];

    dmem_hs_ctrl_lane_align u_align (
        .op       (al_op),
        .lane     (al_lane),
        .wdata    (bus.req_wdata),
        .rword    (rword),
        .be       (al_be),
        .wdata_al (al_wdata),
        .rdata    (al_rdata),
        .misalign (al_misalign)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RST_STATE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        we_be    = 4'b0000;
        we_idx   = clr_ptr;
        we_data  = 32'h0;
        case (state)
            ST_CLEAR: begin
                we_be = 4'b1111;
                if (clr_ptr == AW'(DEPTH - 1)) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nx = ST_RESP;
                    end else if (is_load(bus.req_op)) begin
                        state_nx = ST_LOAD_WAIT;
                    end else begin
                        state_nx = ST_RESP;
                        we_be    = al_be;
                        we_idx   = bus.req_addr[AW+1:2];
                        we_data  = al_wdata;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (lat_done) state_nx = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            clr_ptr     <= '0;
            lat_cnt     <= 3'd0;
            op_q        <= OP_LB;
            word_q      <= '0;
            lane_q      <= 2'b00;
        end else begin
            // Registered so ready stays low through reset even when the
            // zero-fill is disabled and the FSM resets straight into IDLE.
            req_ready_q <= (state_nx == ST_IDLE);
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.req_op;
                        word_q  <= bus.req_addr[AW+1:2];
                        lane_q  <= bus.req_addr[1:0];
                        lat_cnt <= 3'd0;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                    end
                end
                ST_LOAD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_done) begin
                        rdata_q <= al_rdata;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array has no reset; contents are defined only by the zero-fill.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_be[b]) mem[we_idx][8*b +: 8] <= we_data[8*b +: 8];
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy_clr      = (state == ST_CLEAR);

endmodule

// File: tb/tb_dmem_hs_ctrl.sv
// Self-checking bench for dmem_hs_ctrl (DEPTH=16, RD_LAT=3, CLR_EN=1).
// Expected responses are queued at accept and compared by a monitor when
// the response handshake completes.
module tb_dmem_hs_ctrl;
    import dmem_hs_ctrl_pkg::*;

    localparam int DEPTH  = 16;
    localparam int RD_LAT = 3;
    localparam int NV     = 24;

    typedef struct {
        mem_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy_clr;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];
    vec_t vt[NV];

    dmem_hs_ctrl_if bus();

    dmem_hs_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .CLR_EN(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy_clr (busy_clr)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_rdata"}, bus.rsp_rdata, e.rdata);
                chk({e.nm, "_err"}, 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Counts busy_clr cycles after reset release; no response may appear.
    task automatic clear_count(input string nm);
        int cnt;
        bit saw_valid;
        cnt = 0;
        saw_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_valid = 1'b1;
            if (busy_clr) cnt++;
            else break;
        end
        chk({nm, "_busy_cycles"}, 32'(cnt), 32'(DEPTH));
        chk({nm, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        chk({nm, "_no_rsp"}, 32'(saw_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    // Entered and left just after a rising edge.
    task automatic do_req(input string nm, input mem_op_e op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat, input int hold);
        bit ok;
        int lat;
        logic [31:0] rd0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = (hold == 0);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk);
        sb.push_back('{nm, exp_rd, exp_err});
        #1;
        // Garbage after accept must be ignored.
        bus.req_valid = 1'b0;
        bus.req_op    = OP_SW;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'hFFFF_FFFF;
        lat = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin lat = n; break; end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        if (hold > 0) begin
            rd0 = bus.rsp_rdata;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({nm, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                chk({nm, "_hold_rdata"}, bus.rsp_rdata, rd0);
                chk({nm, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            end
            @(posedge clk); #1;
            bus.rsp_ready = 1'b1;
        end
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!bus.rsp_valid) begin ok = 1'b1; break; end
        end
        chk({nm, "_rsp_drop"}, 32'(ok), 32'd1);
        chk({nm, "_ready_back"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        int lat_e;
        bit saw_valid;

        vt[0]  = '{OP_LW,  32'h0000_003C, 32'h0,          32'h0000_0000, 1'b0};
        vt[1]  = '{OP_SW,  32'h0000_0010, 32'hDEAD_BEEF,  32'h0000_0000, 1'b0};
        vt[2]  = '{OP_LB,  32'h0000_0013, 32'h0,          32'hFFFF_FFDE, 1'b0};
        vt[3]  = '{OP_LBU, 32'h0000_0011, 32'h0,          32'h0000_00BE, 1'b0};
        vt[4]  = '{OP_LH,  32'h0000_0012, 32'h0,          32'hFFFF_DEAD, 1'b0};
        vt[5]  = '{OP_LHU, 32'h0000_0010, 32'h0,          32'h0000_BEEF, 1'b0};
        vt[6]  = '{OP_SH,  32'h0000_0020, 32'hFFFF_1234,  32'h0000_0000, 1'b0};
        vt[7]  = '{OP_SB,  32'h0000_0023, 32'h1234_56AB,  32'h0000_0000, 1'b0};
        vt[8]  = '{OP_LW,  32'h0000_0020, 32'h0,          32'hAB00_1234, 1'b0};
        vt[9]  = '{OP_LW,  32'h0000_0022, 32'h0,          32'h0000_0000, 1'b1};
        vt[10] = '{OP_SH,  32'h0000_0021, 32'h0000_5555,  32'h0000_0000, 1'b1};
        vt[11] = '{OP_LW,  32'h0000_0040, 32'h0,          32'h0000_0000, 1'b1};
        vt[12] = '{OP_SW,  32'h0000_0040, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
        vt[13] = '{OP_SW,  32'h0000_0012, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
        vt[14] = '{OP_LW,  32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vt[15] = '{OP_LW,  32'h0000_0020, 32'h0,          32'hAB00_1234, 1'b0};
        vt[16] = '{OP_SB,  32'h0000_0000, 32'h0000_007F,  32'h0000_0000, 1'b0};
        vt[17] = '{OP_LB,  32'h0000_0000, 32'h0,          32'h0000_007F, 1'b0};
        vt[18] = '{OP_LH,  32'h0000_0002, 32'h0,          32'h0000_0000, 1'b0};
        vt[19] = '{OP_SW,  32'h0000_003C, 32'h8000_0001,  32'h0000_0000, 1'b0};
        vt[20] = '{OP_LH,  32'h0000_003E, 32'h0,          32'hFFFF_8000, 1'b0};
        vt[21] = '{OP_LHU, 32'h0000_003E, 32'h0,          32'h0000_8000, 1'b0};
        vt[22] = '{OP_LB,  32'h0000_003C, 32'h0,          32'h0000_0001, 1'b0};
        vt[23] = '{OP_LW,  32'hFFFF_FFFC, 32'h0,          32'h0000_0000, 1'b1};

        bus.req_valid = 1'b0;
        bus.req_op    = OP_LB;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        reset_n       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("rst_busy_clr",  32'(busy_clr), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_count("clear1");

        // Table-driven loads/stores/errors
        for (int i = 0; i < NV; i++) begin
            lat_e = (vt[i].err || is_store(vt[i].op)) ? 1 : RD_LAT + 1;
            do_req($sformatf("v%0d", i), vt[i].op, vt[i].addr, vt[i].wdata,
                   vt[i].rdata, vt[i].err, lat_e, 0);
        end

        // Response back-pressure, then a following request
        do_req("hold_lw", OP_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, RD_LAT + 1, 5);
        do_req("after_hold", OP_LW, 32'h20, 32'h0, 32'hAB00_1234, 1'b0, RD_LAT + 1, 0);

        // Reset during load wait
        do_req("pre_rst_sw", OP_SW, 32'h30, 32'h55AA_55AA, 32'h0, 1'b0, 1, 0);
        do_req("pre_rst_lw", OP_LW, 32'h30, 32'h0, 32'h55AA_55AA, 1'b0, RD_LAT + 1, 0);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'h30;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        chk("midrst_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_wait_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",      32'(busy_clr), 32'd1);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        saw_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        chk("midrst_no_rsp", 32'(saw_valid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_count("clear2");
        do_req("post_rst_lw30", OP_LW, 32'h30, 32'h0, 32'h0, 1'b0, RD_LAT + 1, 0);
        do_req("post_rst_lw10", OP_LW, 32'h10, 32'h0, 32'h0, 1'b0, RD_LAT + 1, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
